// File: rtl/mem_multiport_bank_arbiter.sv
// mem_multiport_bank_arbiter
//   Per-bank N:1 arbiter between NumPorts memory-stream requestors and NumBanks SRAM banks.
//   Each bank arbitrates independently (round-robin, or port-0 priority with a starvation
//   bound) and keeps an in-order route store so that each response returns to the port that
//   was granted the matching request.
//
// Ports (flattened; requestor vectors are indexed [p][b] -> element p*NumBanks+b)
//   clk_i, rst_i        clock, synchronous active-high reset
//   port_req_i/gnt_o    per port/bank request and grant
//   port_addr_i, port_wdata_i, port_strb_i, port_we_i, port_atop_i   request payload
//   port_rvalid_o       response valid, routed to the port at the head of the route store
//   port_rdata_o        mem_rdata_i of each bank broadcast to every port
//   mem_*_o / mem_*_i   per-bank memory side, same payload widths
//   err_o               sticky per bank: a response arrived with the route store empty
//
// Optional feature macro: MEM_ARB_FULL_GUARD_EN
//   Defined: a bank with a full, non-popping route store suppresses mem_req_o and grants,
//   so the memory may exceed BufDepth latency. Undefined: no gating; overflow is only asserted.
module mem_multiport_bank_arbiter #(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned NumBanks    = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned BufDepth    = 1,
    parameter int unsigned PrioMode    = 0,
    parameter int unsigned StarveLimit = 4,
    localparam int unsigned IdxW       = $clog2(NumPorts),
    localparam int unsigned StrbW      = DataWidth / 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumPorts*NumBanks-1:0]         port_req_i,
    output logic [NumPorts*NumBanks-1:0]         port_gnt_o,
    input  logic [NumPorts*NumBanks*AddrWidth-1:0] port_addr_i,
    input  logic [NumPorts*NumBanks*DataWidth-1:0] port_wdata_i,
    input  logic [NumPorts*NumBanks*StrbW-1:0]   port_strb_i,
    input  logic [NumPorts*NumBanks-1:0]         port_we_i,
    input  logic [NumPorts*NumBanks*6-1:0]       port_atop_i,
    output logic [NumPorts*NumBanks-1:0]         port_rvalid_o,
    output logic [NumPorts*NumBanks*DataWidth-1:0] port_rdata_o,
    output logic [NumBanks-1:0]                  mem_req_o,
    input  logic [NumBanks-1:0]                  mem_gnt_i,
    output logic [NumBanks*AddrWidth-1:0]        mem_addr_o,
    output logic [NumBanks*DataWidth-1:0]        mem_wdata_o,
    output logic [NumBanks*StrbW-1:0]            mem_strb_o,
    output logic [NumBanks-1:0]                  mem_we_o,
    output logic [NumBanks*6-1:0]                mem_atop_o,
    input  logic [NumBanks-1:0]                  mem_rvalid_i,
    input  logic [NumBanks*DataWidth-1:0]        mem_rdata_i,
    output logic [NumBanks-1:0]                  err_o
);

    localparam int unsigned Depth   = BufDepth + 1;
    localparam int unsigned PtrW    = $clog2(Depth);
    localparam int unsigned CntW    = $clog2(Depth + 1);
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [NumPorts-1:0]  req;
        logic [NumPorts-1:0]  cand;
        logic [IdxW-1:0]      arb_idx;
        logic [IdxW-1:0]      winner;
        logic                 found;
        logic                 prio_win;
        int unsigned          idx;
        logic                 any_req;
        logic                 low_req;
        logic                 full;
        logic                 blocked;
        logic                 hs;
        logic                 pop;
        logic                 push_ok;
        logic [AddrWidth-1:0] addr_sel;
        logic [DataWidth-1:0] wdata_sel;
        logic [StrbW-1:0]     strb_sel;
        logic                 we_sel;
        logic [5:0]           atop_sel;

        logic [IdxW-1:0]      rr_q;
        logic                 locked_q;
        logic [IdxW-1:0]      lock_idx_q;
        logic [StarveW-1:0]   starve_q;
        logic [IdxW-1:0]      store_q [Depth];
        logic [PtrW-1:0]      wptr_q;
        logic [PtrW-1:0]      rptr_q;
        logic [CntW-1:0]      cnt_q;
        logic                 err_q;

        for (genvar p = 0; p < NumPorts; p++) begin : g_port
            assign req[p] = port_req_i[p*NumBanks+b];
            assign port_gnt_o[p*NumBanks+b]    = hs && (winner == IdxW'(p));
            assign port_rvalid_o[p*NumBanks+b] = pop && (store_q[rptr_q] == IdxW'(p));
            assign port_rdata_o[(p*NumBanks+b)*DataWidth +: DataWidth] =
                mem_rdata_i[b*DataWidth +: DataWidth];
        end

        // Round-robin search from rr_q; in priority mode port 0 is taken out of the
        // search and only wins through prio_win (i.e. when it is not being starved out).
        always_comb begin
            cand     = req;
            arb_idx  = '0;
            found    = 1'b0;
            idx      = 0;
            prio_win = 1'b0;
            if (PrioMode == 1) begin
                cand[0]  = 1'b0;
                prio_win = req[0] && (starve_q != StarveW'(StarveLimit));
            end
            for (int unsigned i = 0; i < NumPorts; i++) begin
                idx = (32'(rr_q) + i) % NumPorts;
                if (!found && cand[idx[IdxW-1:0]]) begin
                    found   = 1'b1;
                    arb_idx = idx[IdxW-1:0];
                end
            end
            // No candidate left (e.g. only a starving-limit port 0): default index 0 is right.
            if (prio_win) begin
                arb_idx = '0;
            end
        end

        assign winner  = locked_q ? lock_idx_q : arb_idx;
        assign any_req = |req;
        assign low_req = |req[NumPorts-1:1];
        assign full    = (cnt_q == CntW'(Depth));
        assign pop     = mem_rvalid_i[b] && (cnt_q != '0);

`ifdef MEM_ARB_FULL_GUARD_EN
        assign blocked = full && !mem_rvalid_i[b];
`else
        assign blocked = 1'b0;
`endif

        assign mem_req_o[b] = any_req && !rst_i && !blocked;
        assign hs           = mem_req_o[b] && mem_gnt_i[b];
        // A push into a full store is only accepted when the head leaves the same cycle.
        assign push_ok      = hs && (!full || pop);

        always_comb begin
            addr_sel  = '0;
            wdata_sel = '0;
            strb_sel  = '0;
            we_sel    = 1'b0;
            atop_sel  = '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (winner == IdxW'(p)) begin
                    addr_sel  = port_addr_i[(p*NumBanks+b)*AddrWidth +: AddrWidth];
                    wdata_sel = port_wdata_i[(p*NumBanks+b)*DataWidth +: DataWidth];
                    strb_sel  = port_strb_i[(p*NumBanks+b)*StrbW +: StrbW];
                    we_sel    = port_we_i[p*NumBanks+b];
                    atop_sel  = port_atop_i[(p*NumBanks+b)*6 +: 6];
                end
            end
        end

        assign mem_addr_o[b*AddrWidth +: AddrWidth]  = addr_sel;
        assign mem_wdata_o[b*DataWidth +: DataWidth] = wdata_sel;
        assign mem_strb_o[b*StrbW +: StrbW]          = strb_sel;
        assign mem_we_o[b]                           = we_sel;
        assign mem_atop_o[b*6 +: 6]                  = atop_sel;
        assign err_o[b]                              = err_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q       <= '0;
                locked_q   <= 1'b0;
                lock_idx_q <= '0;
                starve_q   <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                cnt_q      <= '0;
                err_q      <= 1'b0;
                for (int unsigned i = 0; i < Depth; i++) begin
                    store_q[i] <= '0;
                end
            end else begin
                // Hold the chosen port until its request is accepted.
                locked_q   <= any_req && !hs;
                lock_idx_q <= winner;

                if (hs) begin
                    rr_q <= (winner == IdxW'(NumPorts - 1)) ? '0 : winner + IdxW'(1);
                end

                if (hs && (winner != '0)) begin
                    starve_q <= '0;
                end else if (low_req && (starve_q != StarveW'(StarveLimit))) begin
                    starve_q <= starve_q + StarveW'(1);
                end

                if (push_ok) begin
                    store_q[wptr_q] <= winner;
                    wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
                end
                if (pop) begin
                    rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
                end
                case ({push_ok, pop})
                    2'b10:   cnt_q <= cnt_q + CntW'(1);
                    2'b01:   cnt_q <= cnt_q - CntW'(1);
                    default: ;
                endcase

                if (mem_rvalid_i[b] && (cnt_q == '0)) begin
                    err_q <= 1'b1;
                end

`ifndef SYNTHESIS
                assert (!(hs && full && !pop))
                else $error("route store overflow on bank %0d", b);
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_multiport_bank_arbiter.sv
module tb_mem_multiport_bank_arbiter;

    localparam int unsigned RP = 3;
    localparam int unsigned RB = 4;
    localparam int unsigned PP = 2;
    localparam int unsigned PB = 1;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Round-robin instance: 3 ports, 4 banks
    logic [RP*RB-1:0]    req_rr, gnt_rr, we_rr, rvalid_rr;
    logic [RP*RB*AW-1:0] addr_rr;
    logic [RP*RB*DW-1:0] wdata_rr, rdata_rr;
    logic [RP*RB*SW-1:0] strb_rr;
    logic [RP*RB*6-1:0]  atop_rr;
    logic [RB-1:0]       mreq_rr, mgnt_rr, mwe_rr, mrvalid_rr, err_rr;
    logic [RB*AW-1:0]    maddr_rr;
    logic [RB*DW-1:0]    mwdata_rr, mrdata_rr;
    logic [RB*SW-1:0]    mstrb_rr;
    logic [RB*6-1:0]     matop_rr;

    // Priority instance: 2 ports, 1 bank
    logic [PP*PB-1:0]    req_pr, gnt_pr, we_pr, rvalid_pr;
    logic [PP*PB*AW-1:0] addr_pr;
    logic [PP*PB*DW-1:0] wdata_pr, rdata_pr;
    logic [PP*PB*SW-1:0] strb_pr;
    logic [PP*PB*6-1:0]  atop_pr;
    logic [PB-1:0]       mreq_pr, mgnt_pr, mwe_pr, mrvalid_pr, err_pr;
    logic [PB*AW-1:0]    maddr_pr;
    logic [PB*DW-1:0]    mwdata_pr, mrdata_pr;
    logic [PB*SW-1:0]    mstrb_pr;
    logic [PB*6-1:0]     matop_pr;

    mem_multiport_bank_arbiter #(
        .NumPorts(RP), .NumBanks(RB), .AddrWidth(AW), .DataWidth(DW),
        .BufDepth(1), .PrioMode(0), .StarveLimit(4)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .port_req_i(req_rr), .port_gnt_o(gnt_rr), .port_addr_i(addr_rr),
        .port_wdata_i(wdata_rr), .port_strb_i(strb_rr), .port_we_i(we_rr),
        .port_atop_i(atop_rr), .port_rvalid_o(rvalid_rr), .port_rdata_o(rdata_rr),
        .mem_req_o(mreq_rr), .mem_gnt_i(mgnt_rr), .mem_addr_o(maddr_rr),
        .mem_wdata_o(mwdata_rr), .mem_strb_o(mstrb_rr), .mem_we_o(mwe_rr),
        .mem_atop_o(matop_rr), .mem_rvalid_i(mrvalid_rr), .mem_rdata_i(mrdata_rr),
        .err_o(err_rr)
    );

    mem_multiport_bank_arbiter #(
        .NumPorts(PP), .NumBanks(PB), .AddrWidth(AW), .DataWidth(DW),
        .BufDepth(1), .PrioMode(1), .StarveLimit(4)
    ) dut_pr (
        .clk_i(clk), .rst_i(rst),
        .port_req_i(req_pr), .port_gnt_o(gnt_pr), .port_addr_i(addr_pr),
        .port_wdata_i(wdata_pr), .port_strb_i(strb_pr), .port_we_i(we_pr),
        .port_atop_i(atop_pr), .port_rvalid_o(rvalid_pr), .port_rdata_o(rdata_pr),
        .mem_req_o(mreq_pr), .mem_gnt_i(mgnt_pr), .mem_addr_o(maddr_pr),
        .mem_wdata_o(mwdata_pr), .mem_strb_o(mstrb_pr), .mem_we_o(mwe_pr),
        .mem_atop_o(matop_pr), .mem_rvalid_i(mrvalid_pr), .mem_rdata_i(mrdata_pr),
        .err_o(err_pr)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [31:0] exp_addr(input int p, input int b);
        return {16'hA000 + 16'(p), 16'(b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int w;
        int prev_w;

        rst        = 1'b1;
        req_rr     = '1;
        mgnt_rr    = '0;
        mrvalid_rr = '0;
        mrdata_rr  = '0;
        wdata_rr   = '0;
        strb_rr    = '0;
        we_rr      = '0;
        atop_rr    = '0;
        req_pr     = '1;
        mgnt_pr    = '0;
        mrvalid_pr = '0;
        mrdata_pr  = '0;
        wdata_pr   = '0;
        strb_pr    = '0;
        we_pr      = '0;
        atop_pr    = '0;
        for (int p = 0; p < int'(RP); p++) begin
            for (int b = 0; b < int'(RB); b++) begin
                addr_rr[(p*RB+b)*AW +: AW] = exp_addr(p, b);
            end
        end
        for (int p = 0; p < int'(PP); p++) begin
            addr_pr[p*AW +: AW] = exp_addr(p, 0);
        end

        // Reset with every request raised
        cyc();
        settle();
        check("rst_mem_req", 64'(mreq_rr), 64'h0);
        check("rst_gnt", 64'(gnt_rr), 64'h0);
        check("rst_err", 64'(err_rr), 64'h0);
        check("rst_pr_mem_req", 64'(mreq_pr), 64'h0);
        check("rst_pr_gnt", 64'(gnt_pr), 64'h0);

        // Release: bank 0 grants port 0 first
        cyc();
        rst     = 1'b0;
        req_pr  = '0;
        mgnt_rr = 4'b0001;
        settle();
        check("first_gnt", 64'(gnt_rr), 64'h001);
        check("first_mem_req", 64'(mreq_rr), 64'hF);
        check("first_addr", 64'(maddr_rr[0 +: AW]), 64'(exp_addr(0, 0)));

        cyc();
        req_rr     = '0;
        mgnt_rr    = '0;
        mrvalid_rr = 4'b0001;
        mrdata_rr[0 +: DW] = 32'hDEAD_BEEF;
        settle();
        check("first_rvalid", 64'(rvalid_rr), 64'h001);
        check("rdata_bcast", 64'(rdata_rr[(2*RB+0)*DW +: DW]), 64'hDEAD_BEEF);

        // Round-robin on bank 1: grants 0,1,2,0,1,2; response one cycle later
        prev_w = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            req_rr     = 12'h222;
            mgnt_rr    = 4'b0010;
            mrvalid_rr = (k > 0) ? 4'b0010 : 4'b0000;
            settle();
            w = k % 3;
            check($sformatf("rr_gnt%0d", k), 64'(gnt_rr), 64'(1) << (w*4 + 1));
            check($sformatf("rr_addr%0d", k), 64'(maddr_rr[1*AW +: AW]), 64'(exp_addr(w, 1)));
            if (k > 0) begin
                check($sformatf("rr_rvalid%0d", k), 64'(rvalid_rr),
                      64'(1) << (prev_w*4 + 1));
            end
            prev_w = w;
        end
        cyc();
        req_rr     = '0;
        mgnt_rr    = '0;
        mrvalid_rr = 4'b0010;
        settle();
        check("rr_drain_rvalid", 64'(rvalid_rr), 64'h200);

        // Lock on bank 2: port 1 held for 3 stalled cycles while port 0 joins
        cyc();
        mrvalid_rr = '0;
        req_rr     = 12'h040;
        settle();
        check("lock_addr0", 64'(maddr_rr[2*AW +: AW]), 64'(exp_addr(1, 2)));
        check("lock_gnt0", 64'(gnt_rr), 64'h0);
        cyc();
        req_rr = 12'h044;
        settle();
        check("lock_addr1", 64'(maddr_rr[2*AW +: AW]), 64'(exp_addr(1, 2)));
        cyc();
        settle();
        check("lock_addr2", 64'(maddr_rr[2*AW +: AW]), 64'(exp_addr(1, 2)));
        cyc();
        mgnt_rr = 4'b0100;
        settle();
        check("lock_gnt3", 64'(gnt_rr), 64'h040);
        cyc();
        req_rr     = 12'h004;
        mrvalid_rr = 4'b0100;
        settle();
        check("lock_next_gnt", 64'(gnt_rr), 64'h004);
        check("lock_rvalid_p1", 64'(rvalid_rr), 64'h040);
        cyc();
        req_rr  = '0;
        mgnt_rr = '0;
        settle();
        check("lock_rvalid_p0", 64'(rvalid_rr), 64'h004);

        // Bank 3 route store fills (2 outstanding), then push+pop at full
        cyc();
        mrvalid_rr = '0;
        req_rr     = 12'h088;
        mgnt_rr    = 4'b1000;
        settle();
        check("full_gnt0", 64'(gnt_rr), 64'h008);
        cyc();
        settle();
        check("full_gnt1", 64'(gnt_rr), 64'h080);
        cyc();
        req_rr     = 12'h800;
        mrvalid_rr = 4'b1000;
        settle();
        check("full_pushpop_gnt", 64'(gnt_rr), 64'h800);
        check("full_pushpop_rvalid", 64'(rvalid_rr), 64'h008);
        cyc();
        req_rr  = '0;
        mgnt_rr = '0;
        settle();
        check("full_rvalid_p1", 64'(rvalid_rr), 64'h080);
        cyc();
        settle();
        check("full_rvalid_p2", 64'(rvalid_rr), 64'h800);
        check("full_no_err", 64'(err_rr), 64'h0);

        // Spurious response on bank 2
        cyc();
        mrvalid_rr = 4'b0100;
        settle();
        check("spur_rvalid", 64'(rvalid_rr), 64'h0);
        cyc();
        mrvalid_rr = '0;
        settle();
        check("spur_err", 64'(err_rr), 64'h4);
        cyc();
        settle();
        check("spur_err_sticky", 64'(err_rr), 64'h4);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("spur_err_cleared", 64'(err_rr), 64'h0);

        // Priority with starvation bound 4: 0,0,0,0,1 repeating
        prev_w = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            req_pr     = 2'b11;
            mgnt_pr    = 1'b1;
            mrvalid_pr = (k > 0) ? 1'b1 : 1'b0;
            settle();
            w = (k % 5 == 4) ? 1 : 0;
            check($sformatf("prio_gnt%0d", k), 64'(gnt_pr), 64'(1) << w);
            check($sformatf("prio_addr%0d", k), 64'(maddr_pr), 64'(exp_addr(w, 0)));
            if (k > 0) begin
                check($sformatf("prio_rvalid%0d", k), 64'(rvalid_pr), 64'(1) << prev_w);
            end
            prev_w = w;
        end
        cyc();
        req_pr     = '0;
        mgnt_pr    = '0;
        mrvalid_pr = 1'b1;
        settle();
        check("prio_drain_rvalid", 64'(rvalid_pr), 64'h2);
        check("prio_no_err", 64'(err_pr), 64'h0);
        cyc();
        mrvalid_pr = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
